// File: rtl/drive_sequencer_if.sv
// drive_sequencer_if: motion command in, per-motor duty/direction out
interface drive_sequencer_if;
    logic [2:0] cmd;
    logic estop;
    logic [9:0] left_duty;
    logic [9:0] right_duty;
    logic [1:0] l_IN;
    logic [1:0] r_IN;
    logic at_target;
    modport master (output cmd, estop, input left_duty, right_duty, l_IN, r_IN, at_target);
    modport slave (input cmd, estop, output left_duty, right_duty, l_IN, r_IN, at_target);
endinterface

// File: rtl/drive_sequencer.sv
// drive_sequencer: maps motion commands to slew-limited motor duty and direction,
// with a coast dead time inserted on every forward/backward reversal.
module drive_sequencer #(
    parameter int RAMP_DIV = 100000,
    parameter int RAMP_STEP = 32,
    parameter int DEAD_TICKS = 20,
    parameter int FAST_DUTY = 800,
    parameter int SLOW_DUTY = 500
) (
    input logic clk,
    input logic reset,
    drive_sequencer_if.slave bus
);
    localparam int CW = $clog2(RAMP_DIV);
    localparam int DW = $clog2(DEAD_TICKS + 1);
    localparam logic [1:0] FWD = 2'b10, BWD = 2'b01, COAST = 2'b00;
    localparam logic [9:0] FAST = 10'(FAST_DUTY), SLOW = 10'(SLOW_DUTY);
    localparam logic [10:0] STEP = 11'(RAMP_STEP);

    typedef enum logic {RUN, DEAD} state_t;

    logic [CW-1:0] tick_cnt;
    logic tick;
    logic [1:0] tgt_dir [2];
    logic [9:0] tgt_duty [2];
    logic [1:0] settled;
    logic at_target;

    // One step toward t, clamped so the duty never overshoots the target.
    function automatic logic [9:0] ramp(input logic [9:0] d, input logic [9:0] t);
        logic [10:0] up, dn;
        up = {1'b0, d} + STEP;
        dn = {1'b0, d} - STEP;
        return d < t ? (up > {1'b0, t} ? t : up[9:0])
             : d > t ? (({1'b0, d} <= STEP || dn < {1'b0, t}) ? t : dn[9:0]) : d;
    endfunction

    assign tick = tick_cnt == CW'(RAMP_DIV - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) tick_cnt <= '0;
        else tick_cnt <= tick ? '0 : tick_cnt + CW'(1);

    // Index 0 is the left wheel, index 1 the right wheel.
    always_comb begin
        tgt_dir = '{COAST, COAST};
        tgt_duty = '{10'd0, 10'd0};
        case (bus.cmd)
            3'd1: begin tgt_dir = '{FWD, FWD}; tgt_duty = '{FAST, FAST}; end
            3'd2: begin tgt_dir = '{FWD, FWD}; tgt_duty = '{SLOW, FAST}; end
            3'd3: begin tgt_dir = '{FWD, FWD}; tgt_duty = '{FAST, SLOW}; end
            3'd4: begin tgt_dir = '{BWD, BWD}; tgt_duty = '{SLOW, SLOW}; end
            3'd5: begin tgt_dir = '{BWD, FWD}; tgt_duty = '{SLOW, SLOW}; end
            3'd6: begin tgt_dir = '{FWD, BWD}; tgt_duty = '{SLOW, SLOW}; end
            default: ;
        endcase
    end

    for (genvar g = 0; g < 2; g++) begin : ch
        state_t state, state_nx;
        logic [1:0] dir, dir_nx;
        logic [9:0] duty, duty_nx;
        logic [DW-1:0] dead, dead_nx;
        logic [9:0] goal;

        always_ff @(posedge clk or posedge reset)
            if (reset) begin
                state <= RUN;
                dir <= COAST;
                duty <= '0;
                dead <= '0;
            end else begin
                state <= state_nx;
                dir <= dir_nx;
                duty <= duty_nx;
                dead <= dead_nx;
            end

        always_comb begin
            state_nx = state;
            dir_nx = dir;
            duty_nx = duty;
            dead_nx = dead;
            goal = (dir == tgt_dir[g] || dir == COAST) ? tgt_duty[g] : 10'd0;
            if (bus.estop) begin
                state_nx = RUN;
                dir_nx = COAST;
                duty_nx = '0;
                dead_nx = '0;
            end else if (tick && state == DEAD) begin
                dead_nx = dead + DW'(1);
                duty_nx = '0;
                if (dead_nx == DW'(DEAD_TICKS)) begin
                    state_nx = RUN;
                    dir_nx = tgt_dir[g];
                end
            end else if (tick) begin
                duty_nx = ramp(duty, goal);
                if (dir == COAST) dir_nx = tgt_dir[g];
                else if (dir != tgt_dir[g] && duty_nx == '0) begin
                    // Reaching zero on a reversal coasts through the dead time first.
                    dir_nx = COAST;
                    state_nx = tgt_dir[g] == COAST ? RUN : DEAD;
                    dead_nx = '0;
                end
            end
        end

        assign settled[g] = state == RUN && duty == tgt_duty[g] && dir == tgt_dir[g];
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) at_target <= 1'b0;
        else at_target <= &settled && !bus.estop;

    assign bus.left_duty = ch[0].duty;
    assign bus.right_duty = ch[1].duty;
    assign bus.l_IN = ch[0].dir;
    assign bus.r_IN = ch[1].dir;
    assign bus.at_target = at_target;
endmodule

// File: tb/tb_drive_sequencer.sv
// tb_drive_sequencer: directed stimulus with a scoreboard of expected output changes
// (value and cycle since reset release) checked by an independent monitor.
module tb_drive_sequencer;
    localparam logic [1:0] F = 2'b10, B = 2'b01, C = 2'b00;

    logic clk, rst0, rst1;
    int cyc0, cyc1;
    int checks = 0, errors = 0;

    typedef struct { int id; int cyc; logic [24:0] v; } exp_t;
    exp_t sb[$];
    logic [24:0] cur [2];
    logic [24:0] prev [2] = '{25'd0, 25'd0};

    drive_sequencer_if b0 ();
    drive_sequencer_if b1 ();

    drive_sequencer #(.RAMP_DIV(4), .RAMP_STEP(100), .DEAD_TICKS(2)) dut0 (.clk(clk), .reset(rst0), .bus(b0));
    drive_sequencer #(.RAMP_DIV(4), .RAMP_STEP(300), .DEAD_TICKS(2)) dut1 (.clk(clk), .reset(rst1), .bus(b1));

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst0)
        if (rst0) cyc0 <= 0;
        else cyc0 <= cyc0 + 1;

    always @(posedge clk or posedge rst1)
        if (rst1) cyc1 <= 0;
        else cyc1 <= cyc1 + 1;

    // Monitor: every change of a DUT's output tuple must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        cur[0] = {b0.l_IN, b0.r_IN, b0.left_duty, b0.right_duty, b0.at_target};
        cur[1] = {b1.l_IN, b1.r_IN, b1.left_duty, b1.right_duty, b1.at_target};
        for (int k = 0; k < 2; k++)
            if (cur[k] != prev[k]) begin
                checks++;
                if (sb.size() == 0 || sb[0].id != k) begin
                    errors++;
                    $display("FAIL dut%0d unexpected change: got %h at cycle %0d", k, cur[k], k ? cyc1 : cyc0);
                end else begin
                    e = sb.pop_front();
                    if (e.v != cur[k] || e.cyc != (k ? cyc1 : cyc0)) begin
                        errors++;
                        $display("FAIL dut%0d output: got %h at cycle %0d, want %h at cycle %0d",
                                 k, cur[k], k ? cyc1 : cyc0, e.v, e.cyc);
                    end
                end
                prev[k] = cur[k];
            end
    end

    task automatic push(input int id, input int cyc, input logic [1:0] l, input logic [1:0] r,
                        input int ld, input int rd, input logic at);
        exp_t e;
        e.id = id;
        e.cyc = cyc;
        e.v = {l, r, 10'(ld), 10'(rd), at};
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic wait_cyc(input int k, input int n);
        int g = 0;
        while ((k ? cyc1 : cyc0) != n && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            checks++;
            errors++;
            $display("FAIL timeout: dut%0d never reached cycle %0d", k, n);
        end
    endtask

    initial begin
        rst0 = 1; rst1 = 1;
        b0.cmd = 3'd1; b0.estop = 0;
        b1.cmd = 3'd2; b1.estop = 0;
        repeat (3) @(negedge clk);
        chk("reset0", {7'd0, b0.l_IN, b0.r_IN, b0.left_duty, b0.right_duty, b0.at_target}, 0);
        chk("reset1", {7'd0, b1.l_IN, b1.r_IN, b1.left_duty, b1.right_duty, b1.at_target}, 0);

        // Forward from reset: 100 per tick up to 800, at_target one cycle later.
        for (int j = 1; j <= 8; j++) push(0, 4 * j, F, F, 100 * j, 100 * j, 0);
        push(0, 33, F, F, 800, 800, 1);
        rst0 = 0;

        // Right turn from settled forward: only the right wheel slows.
        wait_cyc(0, 36);
        b0.cmd = 3'd3;
        push(0, 37, F, F, 800, 800, 0);
        push(0, 40, F, F, 800, 700, 0);
        push(0, 44, F, F, 800, 600, 0);
        push(0, 48, F, F, 800, 500, 0);
        push(0, 49, F, F, 800, 500, 1);

        wait_cyc(0, 52);
        b0.cmd = 3'd1;
        push(0, 53, F, F, 800, 500, 0);
        push(0, 56, F, F, 800, 600, 0);
        push(0, 60, F, F, 800, 700, 0);
        push(0, 64, F, F, 800, 800, 0);
        push(0, 65, F, F, 800, 800, 1);

        // Reversal: ramp to 0, coast two dead ticks, then back up to 500.
        wait_cyc(0, 68);
        b0.cmd = 3'd4;
        push(0, 69, F, F, 800, 800, 0);
        for (int j = 1; j <= 7; j++) push(0, 68 + 4 * j, F, F, 800 - 100 * j, 800 - 100 * j, 0);
        push(0, 100, C, C, 0, 0, 0);
        push(0, 108, B, B, 0, 0, 0);
        for (int j = 1; j <= 5; j++) push(0, 108 + 4 * j, B, B, 100 * j, 100 * j, 0);
        push(0, 129, B, B, 500, 500, 1);

        // Command 7 behaves as stop: ramp down, IN 00 on the zero tick, no dead time.
        wait_cyc(0, 132);
        b0.cmd = 3'd7;
        push(0, 133, B, B, 500, 500, 0);
        for (int j = 1; j <= 4; j++) push(0, 132 + 4 * j, B, B, 500 - 100 * j, 500 - 100 * j, 0);
        push(0, 152, C, C, 0, 0, 0);
        push(0, 153, C, C, 0, 0, 1);

        // Forward ramp interrupted by a one-cycle estop, then restart from coast.
        wait_cyc(0, 156);
        b0.cmd = 3'd1;
        push(0, 157, C, C, 0, 0, 0);
        for (int j = 1; j <= 4; j++) push(0, 156 + 4 * j, F, F, 100 * j, 100 * j, 0);
        push(0, 174, C, C, 0, 0, 0);
        for (int j = 1; j <= 8; j++) push(0, 172 + 4 * j, F, F, 100 * j, 100 * j, 0);
        push(0, 205, F, F, 800, 800, 1);
        wait_cyc(0, 173);
        b0.estop = 1;
        @(negedge clk);
        b0.estop = 0;

        // Reset while in DEAD: after release the reversal target starts from coast at once.
        wait_cyc(0, 208);
        b0.cmd = 3'd4;
        push(0, 209, F, F, 800, 800, 0);
        for (int j = 1; j <= 7; j++) push(0, 208 + 4 * j, F, F, 800 - 100 * j, 800 - 100 * j, 0);
        push(0, 240, C, C, 0, 0, 0);
        wait_cyc(0, 242);
        #2 rst0 = 1;
        @(negedge clk);
        @(negedge clk);
        for (int j = 1; j <= 5; j++) push(0, 4 * j, B, B, 100 * j, 100 * j, 0);
        push(0, 21, B, B, 500, 500, 1);
        rst0 = 0;

        // Reset mid-ramp clears outputs without waiting for a clock edge.
        wait_cyc(0, 24);
        b0.cmd = 3'd1;
        push(0, 25, B, B, 500, 500, 0);
        push(0, 28, B, B, 400, 400, 0);
        push(0, 32, B, B, 300, 300, 0);
        push(0, 0, C, C, 0, 0, 0);
        wait_cyc(0, 33);
        #2 rst0 = 1;
        #1;
        chk("async_reset_duty", {12'd0, b0.left_duty, b0.right_duty}, 0);
        chk("async_reset_in", {28'd0, b0.l_IN, b0.r_IN}, 0);
        repeat (2) @(negedge clk);

        // Large step: clamped at SLOW/FAST on the way up and at 0 on the way down.
        push(1, 4, F, F, 300, 300, 0);
        push(1, 8, F, F, 500, 600, 0);
        push(1, 12, F, F, 500, 800, 0);
        push(1, 13, F, F, 500, 800, 1);
        rst1 = 0;
        wait_cyc(1, 16);
        b1.cmd = 3'd0;
        push(1, 17, F, F, 500, 800, 0);
        push(1, 20, F, F, 200, 500, 0);
        push(1, 24, C, F, 0, 200, 0);
        push(1, 28, C, C, 0, 0, 0);
        push(1, 29, C, C, 0, 0, 1);

        // Spin-left: wheels start in opposite directions from coast.
        wait_cyc(1, 32);
        b1.cmd = 3'd5;
        push(1, 33, C, C, 0, 0, 0);
        push(1, 36, B, F, 300, 300, 0);
        push(1, 40, B, F, 500, 500, 0);
        push(1, 41, B, F, 500, 500, 1);
        wait_cyc(1, 48);

        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
